// File: rtl/cxu_dispatch_if.sv
// Bundle of the CPU-side and CXU-side handshake buses around cxu_dispatch.
// slave: the dispatcher's view; master: the view of the surrounding CPU and CXUs.
interface cxu_dispatch_if #(
    parameter int unsigned N_CXUS     = 1,
    parameter int unsigned CXU_ID_W   = 8,
    parameter int unsigned REQ_ID_W   = 10,
    parameter int unsigned STATE_ID_W = 1,
    parameter int unsigned FUNC_ID_W  = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STATUS_W   = 3
);
    logic                         req_valid;
    logic                         req_ready;
    logic [CXU_ID_W-1:0]          req_cxu_id;
    logic [REQ_ID_W-1:0]          req_id;
    logic [STATE_ID_W-1:0]        req_state_id;
    logic [FUNC_ID_W-1:0]         req_func_id;
    logic [DATA_W-1:0]            req_data0;
    logic [DATA_W-1:0]            req_data1;

    logic                         resp_valid;
    logic                         resp_ready;
    logic [REQ_ID_W-1:0]          resp_id;
    logic [STATUS_W-1:0]          resp_status;
    logic [DATA_W-1:0]            resp_data;

    logic [N_CXUS-1:0]            cxu_req_valid;
    logic [N_CXUS-1:0]            cxu_req_ready;
    logic [REQ_ID_W-1:0]          cxu_req_id;
    logic [STATE_ID_W-1:0]        cxu_req_state_id;
    logic [FUNC_ID_W-1:0]         cxu_req_func_id;
    logic [DATA_W-1:0]            cxu_req_data0;
    logic [DATA_W-1:0]            cxu_req_data1;

    logic [N_CXUS-1:0]            cxu_resp_valid;
    logic [N_CXUS-1:0]            cxu_resp_ready;
    logic [N_CXUS*REQ_ID_W-1:0]   cxu_resp_id;
    logic [N_CXUS*STATUS_W-1:0]   cxu_resp_status;
    logic [N_CXUS*DATA_W-1:0]     cxu_resp_data;

    modport slave (
        input  req_valid, req_cxu_id, req_id, req_state_id, req_func_id, req_data0, req_data1,
        output req_ready,
        output resp_valid, resp_id, resp_status, resp_data,
        input  resp_ready,
        output cxu_req_valid, cxu_req_id, cxu_req_state_id, cxu_req_func_id,
        output cxu_req_data0, cxu_req_data1,
        input  cxu_req_ready,
        input  cxu_resp_valid, cxu_resp_id, cxu_resp_status, cxu_resp_data,
        output cxu_resp_ready
    );

    modport master (
        output req_valid, req_cxu_id, req_id, req_state_id, req_func_id, req_data0, req_data1,
        input  req_ready,
        input  resp_valid, resp_id, resp_status, resp_data,
        output resp_ready,
        input  cxu_req_valid, cxu_req_id, cxu_req_state_id, cxu_req_func_id,
        input  cxu_req_data0, cxu_req_data1,
        output cxu_req_ready,
        output cxu_resp_valid, cxu_resp_id, cxu_resp_status, cxu_resp_data,
        input  cxu_resp_ready
    );
endinterface

// File: rtl/cxu_dispatch.sv
// Routes CX requests to N_CXUS units and returns responses in request order via a tracking FIFO.
// Optional macro CXU_DISPATCH_ID_CHECK_EN: compare returned tags against the head tag.
module cxu_dispatch #(
    parameter int unsigned N_CXUS          = 1,
    parameter int unsigned CXU_ID_W        = 8,
    parameter int unsigned REQ_ID_W        = 10,
    parameter int unsigned STATE_ID_W      = 1,
    parameter int unsigned FUNC_ID_W       = 10,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned STATUS_W        = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    cxu_dispatch_if.slave    bus,
    output logic             err_id_mismatch
);
    localparam int unsigned IDX_W = (N_CXUS > 1) ? $clog2(N_CXUS) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [STATUS_W-1:0] ST_ERROR_CXU    = STATUS_W'(1);
    localparam logic [STATUS_W-1:0] ST_ERROR_CUSTOM = STATUS_W'(6);

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic                bad;
        logic [REQ_ID_W-1:0] id;
    } trk_t;

    trk_t             fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic              full;
    logic              empty;
    logic              bad;
    logic              sel_ready;
    logic [N_CXUS-1:0] req_sel;
    logic              push;
    logic              pop;
    trk_t              head;
    trk_t              new_entry;
    logic              id_mis;

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    assign bad   = (32'(bus.req_cxu_id) >= 32'(N_CXUS));
    assign head  = fifo_q[rd_ptr_q];

    assign new_entry.idx = IDX_W'(bus.req_cxu_id);
    assign new_entry.bad = bad;
    assign new_entry.id  = bus.req_id;

    // Request steering: only the addressed CXU sees valid; out-of-range ids are absorbed locally
    always_comb begin
        sel_ready = 1'b0;
        req_sel   = '0;
        for (int i = 0; i < int'(N_CXUS); i++) begin
            if (!bad && (bus.req_cxu_id == CXU_ID_W'(i))) begin
                sel_ready  = bus.cxu_req_ready[i];
                req_sel[i] = !rst && bus.req_valid && !full;
            end
        end
    end

    assign bus.req_ready        = !rst && !full && (bad || sel_ready);
    assign bus.cxu_req_valid    = req_sel;
    assign bus.cxu_req_id       = bus.req_id;
    assign bus.cxu_req_state_id = bus.req_state_id;
    assign bus.cxu_req_func_id  = bus.req_func_id;
    assign bus.cxu_req_data0    = bus.req_data0;
    assign bus.cxu_req_data1    = bus.req_data1;

    assign push = bus.req_valid && bus.req_ready;

    // Response path: the head entry picks either a local error or one CXU's pass-through
    always_comb begin
        bus.resp_valid     = 1'b0;
        bus.resp_id        = head.id;
        bus.resp_status    = '0;
        bus.resp_data      = '0;
        bus.cxu_resp_ready = '0;
        id_mis             = 1'b0;
        if (!rst && !empty) begin
            if (head.bad) begin
                bus.resp_valid  = 1'b1;
                bus.resp_status = ST_ERROR_CXU;
            end else begin
                for (int i = 0; i < int'(N_CXUS); i++) begin
                    if (head.idx == IDX_W'(i)) begin
                        bus.resp_valid        = bus.cxu_resp_valid[i];
                        bus.resp_id           = bus.cxu_resp_id[i*REQ_ID_W +: REQ_ID_W];
                        bus.resp_status       = bus.cxu_resp_status[i*STATUS_W +: STATUS_W];
                        bus.resp_data         = bus.cxu_resp_data[i*DATA_W +: DATA_W];
                        bus.cxu_resp_ready[i] = bus.resp_ready;
`ifdef CXU_DISPATCH_ID_CHECK_EN
                        id_mis = (bus.cxu_resp_id[i*REQ_ID_W +: REQ_ID_W] != head.id);
`endif
                    end
                end
`ifdef CXU_DISPATCH_ID_CHECK_EN
                if (id_mis) begin
                    bus.resp_status = ST_ERROR_CUSTOM;
                end
`endif
            end
        end
    end

    assign pop = bus.resp_valid && bus.resp_ready;

    // Tracking FIFO storage; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CXU_DISPATCH_ID_CHECK_EN
    // Sticky tag-mismatch flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_id_mismatch <= 1'b0;
        end else if (pop && id_mis) begin
            err_id_mismatch <= 1'b1;
        end
    end
`else
    assign err_id_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cxu_dispatch.sv
// Directed self-checking bench for cxu_dispatch with two attached CXUs.
module tb_cxu_dispatch;
    localparam int unsigned N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int   errors = 0;
    int   checks = 0;

    cxu_dispatch_if #(.N_CXUS(N)) bus ();

    cxu_dispatch #(.N_CXUS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .err_id_mismatch (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid       = 1'b0;
        bus.req_cxu_id      = '0;
        bus.req_id          = '0;
        bus.req_state_id    = '0;
        bus.req_func_id     = '0;
        bus.req_data0       = '0;
        bus.req_data1       = '0;
        bus.resp_ready      = 1'b1;
        bus.cxu_req_ready   = 2'b11;
        bus.cxu_resp_valid  = 2'b00;
        bus.cxu_resp_id     = '0;
        bus.cxu_resp_status = '0;
        bus.cxu_resp_data   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.req_valid = 1'b1;
        step();
        step();
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
        checks++; if (bus.cxu_req_valid !== 2'b00) begin errors++; $display("FAIL rst_cxu_req_valid: got %b want 00", bus.cxu_req_valid); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.cxu_resp_ready !== 2'b00) begin errors++; $display("FAIL rst_cxu_resp_ready: got %b want 00", bus.cxu_resp_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_ordering();
        bus.req_valid  = 1'b1;
        bus.req_cxu_id = 8'd0;
        bus.req_id     = 10'd0;
        #1;
        checks++; if (bus.cxu_req_valid !== 2'b01) begin errors++; $display("FAIL ord_route0: got %b want 01", bus.cxu_req_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ord_ready0: got %b want 1", bus.req_ready); end
        step();
        bus.req_cxu_id = 8'd1;
        bus.req_id     = 10'd1;
        #1;
        checks++; if (bus.cxu_req_valid !== 2'b10) begin errors++; $display("FAIL ord_route1: got %b want 10", bus.cxu_req_valid); end
        step();
        bus.req_valid       = 1'b0;
        bus.cxu_resp_valid  = 2'b10;
        bus.cxu_resp_id     = {10'd1, 10'd0};
        bus.cxu_resp_status = {3'd5, 3'd3};
        bus.cxu_resp_data   = {32'h0000_B1B1, 32'hA0A0_0000};
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ord_hold_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.cxu_resp_ready !== 2'b01) begin errors++; $display("FAIL ord_hold_ready: got %b want 01", bus.cxu_resp_ready); end
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ord_still_held: got %b want 0", bus.resp_valid); end
        bus.cxu_resp_valid = 2'b11;
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL ord_first_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 10'd0) begin errors++; $display("FAIL ord_first_id: got %h want 000", bus.resp_id); end
        checks++; if (bus.resp_data !== 32'hA0A0_0000) begin errors++; $display("FAIL ord_first_data: got %h want a0a00000", bus.resp_data); end
        checks++; if (bus.resp_status !== 3'd3) begin errors++; $display("FAIL ord_first_status: got %0d want 3", bus.resp_status); end
        step();
        bus.cxu_resp_valid = 2'b10;
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL ord_second_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 10'd1) begin errors++; $display("FAIL ord_second_id: got %h want 001", bus.resp_id); end
        checks++; if (bus.resp_data !== 32'h0000_B1B1) begin errors++; $display("FAIL ord_second_data: got %h want 0000b1b1", bus.resp_data); end
        checks++; if (bus.resp_status !== 3'd5) begin errors++; $display("FAIL ord_second_status: got %0d want 5", bus.resp_status); end
        checks++; if (bus.cxu_resp_ready !== 2'b10) begin errors++; $display("FAIL ord_second_ready: got %b want 10", bus.cxu_resp_ready); end
        step();
        bus.cxu_resp_valid = 2'b00;
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ord_empty: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_bad_id();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_cxu_id = 8'd5;
        bus.req_id     = 10'h2A;
        #1;
        checks++; if (bus.cxu_req_valid !== 2'b00) begin errors++; $display("FAIL bad_no_fwd: got %b want 00", bus.cxu_req_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bad_pre_valid: got %b want 0", bus.resp_valid); end
        step();
        bus.req_valid = 1'b0;
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bad_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_status !== 3'd1) begin errors++; $display("FAIL bad_status: got %0d want 1", bus.resp_status); end
        checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL bad_data: got %h want 0", bus.resp_data); end
        checks++; if (bus.resp_id !== 10'h2A) begin errors++; $display("FAIL bad_id: got %h want 02a", bus.resp_id); end
        checks++; if (bus.cxu_resp_ready !== 2'b00) begin errors++; $display("FAIL bad_cxu_rr: got %b want 00", bus.cxu_resp_ready); end
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bad_stall_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 10'h2A) begin errors++; $display("FAIL bad_stall_id: got %h want 02a", bus.resp_id); end
        checks++; if (bus.resp_status !== 3'd1) begin errors++; $display("FAIL bad_stall_status: got %0d want 1", bus.resp_status); end
        checks++; if (bus.cxu_req_valid !== 2'b00) begin errors++; $display("FAIL bad_never_fwd: got %b want 00", bus.cxu_req_valid); end
        bus.resp_ready = 1'b1;
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bad_popped: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            bus.req_valid  = 1'b1;
            bus.req_cxu_id = 8'd0;
            bus.req_id     = 10'(32'h100 + k);
            #1;
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b want 1", k, bus.req_ready); end
            step();
        end
        bus.req_id = 10'h104;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_block: got %b want 0", bus.req_ready); end
        checks++; if (bus.cxu_req_valid !== 2'b00) begin errors++; $display("FAIL full_no_fwd: got %b want 00", bus.cxu_req_valid); end
        step();
        bus.cxu_resp_valid = 2'b01;
        bus.cxu_resp_id    = {10'h0, 10'h100};
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL full_head_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 10'h100) begin errors++; $display("FAIL full_head_id: got %h want 100", bus.resp_id); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b want 0", bus.req_ready); end
        step();
        bus.cxu_resp_valid = 2'b00;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %b want 1", bus.req_ready); end
        checks++; if (bus.cxu_req_valid !== 2'b01) begin errors++; $display("FAIL full_fifth_fwd: got %b want 01", bus.cxu_req_valid); end
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            bus.cxu_resp_valid = 2'b01;
            bus.cxu_resp_id    = {10'h0, 10'(32'h100 + k)};
            #1;
            checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL full_drain_valid%0d: got %b want 1", k, bus.resp_valid); end
            checks++; if (bus.resp_id !== 10'(32'h100 + k)) begin errors++; $display("FAIL full_drain_id%0d: got %h want %h", k, bus.resp_id, 10'(32'h100 + k)); end
            step();
        end
        bus.cxu_resp_valid = 2'b00;
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            bus.req_valid  = 1'b1;
            bus.req_cxu_id = 8'd0;
            bus.req_id     = 10'(7 + k);
            step();
        end
        bus.req_valid      = 1'b0;
        bus.cxu_resp_valid = 2'b01;
        bus.cxu_resp_id    = {10'h0, 10'd7};
        rst = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rmid_req_ready: got %b want 0", bus.req_ready); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_flushed: got %b want 0", bus.resp_valid); end
        checks++; if (bus.cxu_resp_ready !== 2'b00) begin errors++; $display("FAIL rmid_cxu_rr: got %b want 00", bus.cxu_resp_ready); end
        bus.cxu_resp_valid = 2'b00;
        bus.req_valid      = 1'b1;
        bus.req_cxu_id     = 8'd1;
        bus.req_id         = 10'h55;
        #1;
        checks++; if (bus.cxu_req_valid !== 2'b10) begin errors++; $display("FAIL rmid_new_fwd: got %b want 10", bus.cxu_req_valid); end
        step();
        bus.req_valid      = 1'b0;
        bus.cxu_resp_valid = 2'b10;
        bus.cxu_resp_id    = {10'h55, 10'h0};
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL rmid_rt_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 10'h55) begin errors++; $display("FAIL rmid_rt_id: got %h want 055", bus.resp_id); end
        step();
        bus.cxu_resp_valid = 2'b00;
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rt_done: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_id_check();
        logic [2:0] exp_status;
        logic       exp_err;
`ifdef CXU_DISPATCH_ID_CHECK_EN
        exp_status = 3'd6;
        exp_err    = 1'b1;
`else
        exp_status = 3'd0;
        exp_err    = 1'b0;
`endif
        bus.req_valid  = 1'b1;
        bus.req_cxu_id = 8'd0;
        bus.req_id     = 10'h10;
        step();
        bus.req_valid       = 1'b0;
        bus.cxu_resp_valid  = 2'b01;
        bus.cxu_resp_id     = {10'h0, 10'h11};
        bus.cxu_resp_status = '0;
        bus.cxu_resp_data   = {32'h0, 32'h0000_1234};
        #1;
        checks++; if (bus.resp_status !== exp_status) begin errors++; $display("FAIL idc_status: got %0d want %0d", bus.resp_status, exp_status); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL idc_err_early: got %b want 0", err); end
        step();
        bus.cxu_resp_valid = 2'b00;
        #1;
        checks++; if (err !== exp_err) begin errors++; $display("FAIL idc_err_set: got %b want %b", err, exp_err); end
        step();
        step();
        checks++; if (err !== exp_err) begin errors++; $display("FAIL idc_err_sticky: got %b want %b", err, exp_err); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL idc_err_cleared: got %b want 0", err); end
    endtask

    initial begin
        idle();
        test_reset();
        test_ordering();
        test_bad_id();
        test_full();
        test_reset_mid();
        test_id_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
